md_unit_iter: RTL and testbench
===============================

Name: md_unit_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU.
- Computes with a radix-2 shift-add multiplier and a restoring divider, one bit per cycle, rather than with a behavioural operator.
- Adds abort (cancel), a completion pulse, defined divide-by-zero/overflow results and width generalisation.

Parameters:
- WIDTH, 32: operand, HI and LO width; WIDTH ≥ 4, even.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  Clock.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  Launch op; accepted only in IDLE.
- op  in  3  Operation: 000 multu, 001 mult, 010 divu, 011 div, 100 madd, 101 maddu, 110 msub, 111 msubu.
- opa  in  WIDTH  rs operand (dividend / multiplicand); also mthi/mtlo data.
- opb  in  WIDTH  rt operand (divisor / multiplier).
- hl_we  in  1  mthi/mtlo write strobe.
- hl_sel  in  1  1 = HI, 0 = LO target for hl_we.
- cancel  in  1  Abort in-flight op (exception/flush).
- busy  out  1  Op in flight; the pipeline stalls mf/mt/md instructions while high.
- done  out  1  One-cycle pulse when HI/LO is committed by an op.
- hi  out  WIDTH  HI register (registered).
- lo  out  WIDTH  LO register (registered).

Behaviour:
- Reset (sync, highest priority): state = IDLE, hi = lo = 0, busy = 0, done = 0, counter = 0. Reset mid-operation discards the op silently.
- States and transitions:
  - IDLE → CALC on start && !cancel.
  - CALC → FIX after WIDTH iterations.
  - FIX → IDLE.
  - CALC or FIX → IDLE on cancel.
- busy = (state != IDLE), registered.
- done = 1 only in the cycle following the FIX edge.
- Start edge E0:
  - Latch op.
  - Latch |opa| and |opb| (magnitudes for signed ops mult/div/madd/msub; raw values otherwise).
  - Latch result sign: mult-type sign = opa[MSB] ^ opb[MSB]; div quotient sign = opa^opb, remainder sign = opa[MSB].
  - Snapshot {hi, lo} as the accumulator base.
  - Counter = 0.
- CALC, multiply: 2·WIDTH-bit product register; if multiplier LSB = 1, add multiplicand into upper half; then shift right one bit.
- CALC, divide: restoring step. Shift {rem, quo} left one bit; trial-subtract divisor from rem; if non-negative keep and set quo LSB = 1.
- Counter increments every CALC cycle; exits to FIX when counter == WIDTH-1.
- FIX edge (E0+WIDTH+1):
  - Negate the product if sign is set (2·WIDTH-bit two's complement).
  - madd/maddu: {hi, lo} = base + product, modulo 2^(2·WIDTH).
  - msub/msubu: {hi, lo} = base − product, modulo 2^(2·WIDTH).
  - mult/multu: {hi, lo} = product.
  - div/divu: lo = signed-corrected quotient, hi = signed-corrected remainder; remainder sign follows the dividend (truncating division).
- Total latency: busy high for WIDTH+1 cycles; new hi/lo visible from cycle E0+WIDTH+1; done high in that same cycle.
- Divide by zero (opb == 0, divu or div): lo = all ones, hi = opa. The op still takes full latency.
- Signed overflow, div with opa = most-negative and opb = −1: lo = most-negative, hi = 0.
- start while busy: ignored; op and operands unchanged.
- hl_we while busy: ignored.
- hl_we in IDLE: write opa to hi (hl_sel = 1) or lo (hl_sel = 0) at the edge, visible next cycle.
- start && hl_we in the same IDLE cycle: start wins, hl_we dropped.
- start && cancel in IDLE: nothing launched.
- cancel in CALC or FIX (including the FIX cycle itself): next state IDLE, hi/lo retain pre-op values, no done pulse, busy = 0 next cycle.
- All arithmetic is modulo 2^WIDTH or 2^(2·WIDTH); no saturation, no overflow flags.

Test Plan (WIDTH = 32):
- multu, opa = opb = 0xFFFFFFFF → busy high for 33 cycles; then hi = 0xFFFFFFFE, lo = 0x00000001, done pulses once.
- mult, opa = 0xFFFFFFFD (−3), opb = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- div, opa = 0xFFFFFFF9 (−7), opb = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- divu by zero (opa = 0x1234, opb = 0) → lo = 0xFFFFFFFF, hi = 0x00001234.
- div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- mthi 0x00000001, mtlo 0xFFFFFFFF, then maddu 1 × 1 → hi = 0x00000002, lo = 0x00000000 (carry across halves). Then msub 1 × 1 → hi = 0x00000001, lo = 0xFFFFFFFF.
- Start multu 7 × 9, assert cancel at cycle 10 → hi/lo unchanged, no done, busy low at cycle 11.
- Same-cycle start + hl_we → only the op executes.
- start and hl_we during busy → both ignored.
- Reset asserted mid-op → hi = lo = 0, busy = 0.

Source files
------------

// File: rtl/md_unit_iter.sv
// md_unit_iter: iterative shift-add multiply / restoring divide with HI/LO (clk, reset, start/op/opa/opb, hl_we/hl_sel, cancel -> busy, done, hi, lo)
module md_unit_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hl_we,
  input  logic             hl_sel,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sgn_q, sgn_d, rsgn_q, rsgn_d, dz_q, dz_d, busy_q, busy_d, done_q, done_d;
  logic sgn_op, is_div, ge;
  logic [WIDTH-1:0] abs_a, abs_b, quo_f, rem_f, rnew;
  logic [WIDTH:0] msum, r2;
  logic [2*WIDTH-1:0] prod_s, mres;
  assign sgn_op = (op == 3'b001) || (op == 3'b011) || (op == 3'b100) || (op == 3'b110);
  assign is_div = op[2:1] == 2'b01;
  assign abs_a = (sgn_op && opa[WIDTH-1]) ? -opa : opa;
  assign abs_b = (sgn_op && opb[WIDTH-1]) ? -opb : opb;
  assign msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
  assign r2 = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign ge = r2 >= {1'b0, b_q};
  assign rnew = ge ? WIDTH'(r2 - {1'b0, b_q}) : r2[WIDTH-1:0];
  assign prod_s = sgn_q ? -prod_q : prod_q;
  assign mres = kind_q[1] ? (kind_q[0] ? {hi_q, lo_q} - prod_s : {hi_q, lo_q} + prod_s) : prod_s;
  // a zero divisor leaves the dividend in the remainder, so only the quotient needs forcing
  assign quo_f = dz_q ? '1 : (sgn_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0]);
  assign rem_f = rsgn_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    kind_d = kind_q;
    b_d = b_q;
    prod_d = prod_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    rsgn_d = rsgn_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    if (state_q == IDLE && start && !cancel) begin
      state_d = CALC;
      kind_d = op[2:1];
      cnt_d = '0;
      b_d = is_div ? abs_b : abs_a;
      prod_d = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
      sgn_d = sgn_op && (opa[WIDTH-1] ^ opb[WIDTH-1]);
      rsgn_d = sgn_op && opa[WIDTH-1];
      dz_d = opb == '0;
    end else if (state_q == IDLE && hl_we && !start) begin
      hi_d = hl_sel ? opa : hi_q;
      lo_d = hl_sel ? lo_q : opa;
    end else if (state_q == CALC) begin
      state_d = cancel ? IDLE : (cnt_q == CNT_W'(WIDTH - 1) ? FIX : CALC);
      cnt_d = cnt_q + CNT_W'(1);
      prod_d = (kind_q == 2'b01) ? {rnew, prod_q[WIDTH-2:0], ge} : {msum, prod_q[WIDTH-1:1]};
    end else if (state_q == FIX) begin
      state_d = IDLE;
      done_d = !cancel;
      {hi_d, lo_d} = cancel ? {hi_q, lo_q} : ((kind_q == 2'b01) ? {rem_f, quo_f} : mres);
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q <= '0;
      b_q <= '0;
      prod_q <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      rsgn_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      b_q <= b_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
      rsgn_q <= rsgn_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_md_unit_iter.sv
// tb_md_unit_iter: reference-model and literal checks of md_unit_iter at WIDTH = 32
module tb_md_unit_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic hl_we = 1'b0;
  logic hl_sel = 1'b0;
  logic cancel = 1'b0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0;
  int errors = 0;
  int nbusy, ndone;
  bit armed = 1'b0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int m_left;
  bit m_done;

  md_unit_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .hl_we(hl_we), .hl_sel(hl_sel), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] base);
    longint sa, sb, sp;
    logic [63:0] up;
    int q, r;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    up = {32'b0, a} * {32'b0, b};
    case (o)
      3'd0: return up;
      3'd1: return sp;
      3'd4: return base + sp;
      3'd5: return base + up;
      3'd6: return base - sp;
      3'd7: return base - up;
      3'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= '0;
      m_lo <= '0;
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (cancel) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            {m_hi, m_lo} <= m_pend;
            m_done <= 1'b1;
          end
        end
      end else if (start && !cancel) begin
        m_pend <= model_res(op, opa, opb, {m_hi, m_lo});
        m_left <= 33;
      end else if (hl_we && !start) begin
        if (hl_sel) m_hi <= opa;
        else m_lo <= opa;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    repeat (33) begin
      nbusy += int'(busy);
      @(negedge clk);
    end
  endtask

  task automatic mt(input logic sel, input logic [31:0] v);
    @(negedge clk);
    hl_we = 1'b1; hl_sel = sel; opa = v;
    @(negedge clk);
    hl_we = 1'b0;
  endtask

  task automatic expect_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    @(posedge clk);
    #1 armed = 1'b1;
    @(negedge clk);
    expect_hl("reset", 32'h0, 32'h0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    go(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_cycles", 64'(nbusy), 64'd33);
    chk("multu_done", 64'(done), 64'd1);
    expect_hl("multu", 32'hFFFF_FFFE, 32'h0000_0001);
    go(3'd1, 32'hFFFF_FFFD, 32'd5);
    expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    go(3'd3, 32'hFFFF_FFF9, 32'd2);
    expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    go(3'd2, 32'h0000_1234, 32'd0);
    expect_hl("divu_zero", 32'h0000_1234, 32'hFFFF_FFFF);
    go(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_hl("div_ovf", 32'h0, 32'h8000_0000);
    mt(1'b1, 32'h1);
    mt(1'b0, 32'hFFFF_FFFF);
    expect_hl("mthi_mtlo", 32'h1, 32'hFFFF_FFFF);
    go(3'd5, 32'd1, 32'd1);
    expect_hl("maddu", 32'h2, 32'h0);
    go(3'd6, 32'd1, 32'd1);
    expect_hl("msub", 32'h1, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'd7; opb = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (35) begin
      ndone += int'(done);
      @(negedge clk);
    end
    chk("cancel_no_done", 64'(ndone), 64'd0);
    expect_hl("cancel", 32'h1, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b1; hl_we = 1'b1; hl_sel = 1'b1; op = 3'd0; opa = 32'd2; opb = 32'd3;
    @(negedge clk);
    start = 1'b0; hl_we = 1'b0;
    repeat (33) @(negedge clk);
    expect_hl("start_wins", 32'h0, 32'h6);
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'd3; opb = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; hl_we = 1'b1; hl_sel = 1'b0; op = 3'd2; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0; hl_we = 1'b0;
    repeat (27) @(negedge clk);
    expect_hl("busy_ignore", 32'h0, 32'hC);
    go(3'd2, 32'd100, 32'd7);
    expect_hl("divu", 32'h2, 32'hE);
    go(3'd4, 32'hFFFF_FFFE, 32'd3);
    expect_hl("madd", 32'h2, 32'h8);
    go(3'd7, 32'hFFFF_FFFF, 32'd2);
    expect_hl("msubu", 32'h0, 32'hA);
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd0; opa = 32'd5; opb = 32'd5;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_idle", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd1; opa = 32'd5; opb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_hl("reset_mid", 32'h0, 32'h0);
    chk("reset_mid_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
